// File: rtl/spi_ram_burst.sv
// spi_ram_burst: framed SPI command decoder driving a parametrised single-port RAM with burst addressing
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (memory contents are kept)
//   rx_valid   din carries a frame this cycle
//   din        {cmd[1:0], payload[DATA_W-1:0]}; cmd 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//   dout       read data, meaningful while tx_valid=1, otherwise holds
//   tx_valid   one-cycle pulse per accepted RD_DATA
//   proto_err  one-cycle pulse per illegal command (bad address or unarmed data access)
//   parity_err present only when RAM_PARITY_EN is defined; pulses with tx_valid on a stored-parity mismatch
//
// Optional feature macro: RAM_PARITY_EN (each word carries an extra even-parity bit)
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              proto_err
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);
`ifdef RAM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  logic [MW-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, addr;
  logic wr_armed_q, wr_armed_d, rd_armed_q, rd_armed_d;
  logic [DATA_W-1:0] dout_q, dout_d, pay;
  logic tx_valid_q, tx_valid_d, proto_err_q, proto_err_d, we, addr_ok;
  logic [1:0] cmd;
  logic [MW-1:0] wr_word, rd_word;
`ifdef RAM_PARITY_EN
  logic parity_err_q, parity_err_d;
`endif
  // Wrap at MEM_DEPTH-1 rather than at the address width so non-power-of-2 depths stay in range
  function automatic logic [ADDR_SIZE-1:0] nxt(input logic [ADDR_SIZE-1:0] a);
    return (AUTO_INC == 0) ? a : (32'(a) == 32'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction
  assign cmd     = din[DATA_W+1:DATA_W];
  assign pay     = din[DATA_W-1:0];
  assign addr    = pay[ADDR_SIZE-1:0];
  assign addr_ok = 32'(addr) < 32'(MEM_DEPTH);
  assign rd_word = mem[rd_addr_q];
`ifdef RAM_PARITY_EN
  assign wr_word = {^pay, pay};
`else
  assign wr_word = pay;
`endif
  always_comb begin
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_armed_d  = wr_armed_q;
    rd_armed_d  = rd_armed_q;
    dout_d      = dout_q;
    tx_valid_d  = 1'b0;
    proto_err_d = 1'b0;
    we          = 1'b0;
`ifdef RAM_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (rx_valid) begin
      case (cmd)
        2'b00: begin
          wr_addr_d   = addr_ok ? addr : wr_addr_q;
          wr_armed_d  = addr_ok;
          proto_err_d = !addr_ok;
        end
        2'b01: begin
          we          = wr_armed_q;
          wr_addr_d   = wr_armed_q ? nxt(wr_addr_q) : wr_addr_q;
          proto_err_d = !wr_armed_q;
        end
        2'b10: begin
          rd_addr_d   = addr_ok ? addr : rd_addr_q;
          rd_armed_d  = addr_ok;
          proto_err_d = !addr_ok;
        end
        default: begin
          tx_valid_d  = rd_armed_q;
          dout_d      = rd_armed_q ? rd_word[DATA_W-1:0] : dout_q;
          rd_addr_d   = rd_armed_q ? nxt(rd_addr_q) : rd_addr_q;
          proto_err_d = !rd_armed_q;
`ifdef RAM_PARITY_EN
          // Even parity over {parity, data} must be zero for a clean word
          parity_err_d = rd_armed_q && (^rd_word);
`endif
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_armed_q  <= 1'b0;
      rd_armed_q  <= 1'b0;
      dout_q      <= '0;
      tx_valid_q  <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef RAM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_armed_q  <= wr_armed_d;
      rd_armed_q  <= rd_armed_d;
      dout_q      <= dout_d;
      tx_valid_q  <= tx_valid_d;
      proto_err_q <= proto_err_d;
`ifdef RAM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end
  // Storage is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) if (we && !rst) mem[wr_addr_q] <= wr_word;
  assign dout      = dout_q;
  assign tx_valid  = tx_valid_q;
  assign proto_err = proto_err_q;
`ifdef RAM_PARITY_EN
  assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: random and directed frames against a queue-based reference model for depths 256 and 200
module tb_spi_ram_burst;
  typedef struct packed {
    logic [1:0] tx, pe, pa;
    logic [1:0][7:0] d;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout_o [2];
  logic [1:0] tx_o, pe_o;
`ifdef RAM_PARITY_EN
  logic [1:0] pa_o;
`endif
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem_m [2][256];
  bit bad_m [2][256];
  int wa [2], ra [2];
  bit wok [2], rok [2];
  logic [7:0] dm [2];
  always #5 clk = ~clk;
  spi_ram_burst #(.MEM_DEPTH(256)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
    .dout(dout_o[0]), .tx_valid(tx_o[0]), .proto_err(pe_o[0])
`ifdef RAM_PARITY_EN
    , .parity_err(pa_o[0])
`endif
  );
  spi_ram_burst #(.MEM_DEPTH(200)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
    .dout(dout_o[1]), .tx_valid(tx_o[1]), .proto_err(pe_o[1])
`ifdef RAM_PARITY_EN
    , .parity_err(pa_o[1])
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic send(input bit r, input bit v, input logic [1:0] c, input logic [7:0] p);
    exp_t e;
    int dep;
    @(negedge clk);
    rst = r; rx_valid = v; din = {c, p};
    e = '0;
    for (int i = 0; i < 2; i++) begin
      dep = (i == 1) ? 200 : 256;
      if (r) begin
        wa[i] = 0; ra[i] = 0; wok[i] = 0; rok[i] = 0; dm[i] = '0;
      end else if (v) begin
        case (c)
          2'd0: if (int'(p) < dep) begin wa[i] = int'(p); wok[i] = 1; end else begin wok[i] = 0; e.pe[i] = 1'b1; end
          2'd1: if (wok[i]) begin mem_m[i][wa[i]] = p; bad_m[i][wa[i]] = 0; wa[i] = (wa[i] + 1) % dep; end else e.pe[i] = 1'b1;
          2'd2: if (int'(p) < dep) begin ra[i] = int'(p); rok[i] = 1; end else begin rok[i] = 0; e.pe[i] = 1'b1; end
          default: if (rok[i]) begin
            dm[i] = mem_m[i][ra[i]]; e.tx[i] = 1'b1; e.pa[i] = bad_m[i][ra[i]];
            ra[i] = (ra[i] + 1) % dep;
          end else e.pe[i] = 1'b1;
        endcase
      end
      e.d[i] = dm[i];
    end
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("tx_valid[%0d]", i), 32'(tx_o[i]), 32'(e.tx[i]));
          chk($sformatf("proto_err[%0d]", i), 32'(pe_o[i]), 32'(e.pe[i]));
          chk($sformatf("dout[%0d]", i), 32'(dout_o[i]), 32'(e.d[i]));
`ifdef RAM_PARITY_EN
          chk($sformatf("parity_err[%0d]", i), 32'(pa_o[i]), 32'(e.pa[i]));
`endif
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 2; i++) for (int a = 0; a < 256; a++) begin mem_m[i][a] = '0; bad_m[i][a] = 0; end
    repeat (2) send(1, 0, 2'd0, 8'h00);
    repeat (5) send(0, 0, 2'd0, 8'h00);
    send(0, 1, 2'd0, 8'h00);
    repeat (256) send(0, 1, 2'd1, 8'($urandom));
    send(0, 1, 2'd0, 8'h10); send(0, 1, 2'd1, 8'hA5);
    send(0, 1, 2'd2, 8'h10); send(0, 1, 2'd3, 8'h00);
    send(0, 0, 2'd0, 8'h00);
    send(0, 1, 2'd0, 8'hFE);
    send(0, 1, 2'd1, 8'h11); send(0, 1, 2'd1, 8'h22); send(0, 1, 2'd1, 8'h33);
    send(0, 1, 2'd2, 8'hFE);
    repeat (3) send(0, 1, 2'd3, 8'h00);
    send(0, 0, 2'd0, 8'h00);
    send(1, 0, 2'd0, 8'h00);
    send(0, 1, 2'd1, 8'h55);
    send(0, 1, 2'd3, 8'h00);
    send(0, 1, 2'd2, 8'h00);
    repeat (2) send(0, 1, 2'd3, 8'h00);
    send(0, 1, 2'd0, 8'hC8);
    send(0, 1, 2'd1, 8'h77);
    send(0, 1, 2'd2, 8'hC7);
    repeat (2) send(0, 1, 2'd3, 8'h00);
`ifdef RAM_PARITY_EN
    send(0, 1, 2'd0, 8'h05); send(0, 1, 2'd1, 8'h3C);
    send(0, 0, 2'd0, 8'h00);
    dut0.mem[5][0] = ~dut0.mem[5][0];
    dut1.mem[5][0] = ~dut1.mem[5][0];
    for (int i = 0; i < 2; i++) begin mem_m[i][5][0] = ~mem_m[i][5][0]; bad_m[i][5] = 1; end
    send(0, 1, 2'd2, 8'h05); send(0, 1, 2'd3, 8'h00);
    send(0, 0, 2'd0, 8'h00);
`endif
    for (int n = 0; n < 3000; n++)
      send($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 2'($urandom), 8'($urandom));
    send(0, 0, 2'd0, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised successor to the SPI-wrapper single-port RAM.
- Decodes framed commands from the SPI slave (rx_valid/din) into write-address, write-data, read-address and read-data operations.
- Returns read data to the slave over tx_valid/dout.
- New over the fixed-width RAM: configurable width/depth, auto-incrementing burst addressing with wrap, protocol-error detection, out-of-range address rejection.

Parameters:
- DATA_W, 8: data payload width; din is DATA_W+2 bits.
- ADDR_SIZE, 8: address bits taken from din[ADDR_SIZE-1:0]; must be <= DATA_W.
- MEM_DEPTH, 256: number of words; must be <= 2**ADDR_SIZE; need not be a power of 2.
- AUTO_INC, 1: 1 = address post-increments after each data access; 0 = address fixed.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  din holds a valid frame this cycle
- din  in  DATA_W+2  [DATA_W+1:DATA_W] = command, [DATA_W-1:0] = payload
- dout  out  DATA_W  read data, valid when tx_valid=1
- tx_valid  out  1  one-cycle pulse per accepted read-data command
- proto_err  out  1  one-cycle pulse on an illegal command
- parity_err  out  1  exists only with RAM_PARITY_EN

Behaviour:
- Reset (rst=1 at edge):
  - dout=0, tx_valid=0, proto_err=0, parity_err=0.
  - wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0.
  - Memory contents not cleared.
  - Reset mid-burst drops arming; the next data command without a fresh address command is an error.
- Commands are sampled only when rx_valid=1. With rx_valid=0: no state change; tx_valid=0 and proto_err=0 next cycle; dout holds.
- 00 WR_ADDR:
  - payload address < MEM_DEPTH: wr_addr <= address, wr_armed <= 1.
  - Otherwise: wr_armed <= 0, proto_err pulses.
- 01 WR_DATA:
  - wr_armed=1: mem[wr_addr] <= payload. If AUTO_INC=1, wr_addr <= (wr_addr==MEM_DEPTH-1) ? 0 : wr_addr+1.
  - wr_armed=0: no write, proto_err pulses.
- 10 RD_ADDR: same as WR_ADDR, but acts on rd_addr and rd_armed.
- 11 RD_DATA:
  - rd_armed=1: dout <= mem[rd_addr] and tx_valid=1 on the next cycle (latency 1). Same wrap/increment rule as WR_DATA.
  - rd_armed=0: proto_err pulses, tx_valid stays 0, dout holds.
- Back-to-back RD_DATA on consecutive cycles gives tx_valid high for the same number of consecutive cycles, with dout advancing per word.
- Any cycle after a non-RD_DATA command, or an RD_DATA error: tx_valid=0.
- Read channel and write channel are independent; arming persists across any number of data commands and idle cycles.
- Write-then-read of the same address on consecutive frames returns the new data (write committed at the edge).
- Payload bits above ADDR_SIZE-1 are ignored for address commands.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed at WR_DATA.
  - On an accepted RD_DATA, parity_err pulses together with tx_valid if the stored parity mismatches.
  - Bench backdoor corruption of a word's data bits must trigger it.
- Undefined:
  - No parity storage; parity_err port absent.
  - Memory is exactly DATA_W wide.

Test Plan:
- Reset, then idle 5 cycles -> dout=0, tx_valid=0, proto_err=0 throughout.
- WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid=1 for exactly one cycle with dout=0xA5; WR/RD_ADDR cycles leave tx_valid=0.
- Burst, AUTO_INC=1, MEM_DEPTH=256:
  - WR_ADDR 0xFE, WR_DATA 0x11/0x22/0x33 -> words 0xFE, 0xFF, 0x00 written.
  - RD_ADDR 0xFE plus 3 back-to-back RD_DATA -> tx_valid high 3 consecutive cycles with dout 0x11, 0x22, 0x33.
- After reset: WR_DATA 0x55 -> proto_err pulse, no memory change. RD_DATA -> proto_err pulse, tx_valid=0.
- MEM_DEPTH=200: WR_ADDR 0xC8 -> proto_err pulse, wr_armed=0; a following WR_DATA -> proto_err pulse.
- With RAM_PARITY_EN: write 0x3C to 0x05, backdoor-flip bit 0, read 0x05 -> tx_valid=1, dout=0x3D, parity_err=1 in the same cycle.
